// File: rtl/dma_priority_arbiter.sv
// 8237A-style DMA request/priority arbiter.
// Sequences DREQ -> HRQ -> HLDA -> DACK and holds one grant per service.
module dma_priority_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  input  logic [NUM_CH-1:0] MASK,
  input  logic [NUM_CH-1:0] SREQ,
  input  logic              DREQ_POL,
  input  logic              DACK_POL,
  input  logic              ROT_PRI,
  input  logic              DISABLE,
  input  logic              SVC_END,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              ACT_VALID,
  output logic [CH_W-1:0]   ACT_CH,
  output logic [NUM_CH-1:0] SREQ_CLR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD_REQ,
    S_ACTIVE
  } state_e;

  state_e            state_q;
  logic              hrq_q;
  logic              act_valid_q;
  logic [CH_W-1:0]   act_ch_q;
  logic [NUM_CH-1:0] grant_q;
  logic [NUM_CH-1:0] sreq_clr_q;
  logic [CH_W-1:0]   top_q;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

  logic [NUM_CH-1:0] eff;
  logic [CH_W-1:0]   start;
  logic [CH_W:0]     sum;
  logic              win_found;
  logic [CH_W-1:0]   win_ch;
  logic [NUM_CH-1:0] win_oh;
  logic [NUM_CH-1:0] act_oh;
  logic [CH_W-1:0]   top_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= DREQ;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign eff = ((sync_q[SYNC_STAGES-1] ^ {NUM_CH{DREQ_POL}})
               & ~MASK) | SREQ;

  assign start = ROT_PRI ? top_q : '0;

  // Circular search from start; index wraps without a modulo operator.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    sum       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, start} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      if (!win_found && eff[sum[CH_W-1:0]]) begin
        win_found = 1'b1;
        win_ch    = sum[CH_W-1:0];
      end
    end
  end

  assign win_oh = NUM_CH'(1) << win_ch;
  assign act_oh = NUM_CH'(1) << act_ch_q;
  assign top_d  = (act_ch_q == CH_W'(NUM_CH-1))
                ? '0 : act_ch_q + CH_W'(1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      hrq_q       <= 1'b0;
      act_valid_q <= 1'b0;
      act_ch_q    <= '0;
      grant_q     <= '0;
      sreq_clr_q  <= '0;
      top_q       <= '0;
    end else begin
      sreq_clr_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (|eff && !DISABLE) begin
            state_q <= S_HOLD_REQ;
            hrq_q   <= 1'b1;
          end
        end
        S_HOLD_REQ: begin
          if (HLDA) begin
            if (win_found) begin
              act_ch_q    <= win_ch;
              grant_q     <= win_oh;
              act_valid_q <= 1'b1;
              state_q     <= S_ACTIVE;
            end else begin
              hrq_q   <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        S_ACTIVE: begin
          if (SVC_END || !HLDA) begin
            grant_q     <= '0;
            act_valid_q <= 1'b0;
            hrq_q       <= 1'b0;
            state_q     <= S_IDLE;
            if (SVC_END) begin
              // Only a pending software request bit needs clearing.
              sreq_clr_q <= act_oh & SREQ;
              if (ROT_PRI) begin
                top_q <= top_d;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign HRQ       = hrq_q;
  assign ACT_VALID = act_valid_q;
  assign ACT_CH    = act_ch_q;
  assign SREQ_CLR  = sreq_clr_q;
  assign DACK      = DACK_POL ? grant_q : ~grant_q;

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Priority/request-arbitration block of the 8237A-compatible DMA controller; implements the PR-side function: DREQ→HRQ→HLDA→DACK sequencing.
- Synchronises and masks channel requests, merges software requests, and raises HRQ to the CPU.
- On HLDA, grants exactly one channel (fixed or rotating priority) and holds the grant until timing control reports end of service.
- Feeds the active channel number to the datapath/timing-control blocks.

Parameters:
- NUM_CH, 4: number of DMA channels (CH_W = $clog2(NUM_CH)).
- SYNC_STAGES, 2: flip-flop stages on each DREQ input (minimum 2).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- DREQ  input  NUM_CH  asynchronous channel request pins.
- HLDA  input  1  hold acknowledge from CPU, synchronous to CLK.
- MASK  input  NUM_CH  mask register; 1 = hardware DREQ ignored.
- SREQ  input  NUM_CH  software request register bits; never masked.
- DREQ_POL  input  1  command bit: 0 = DREQ active-high, 1 = active-low.
- DACK_POL  input  1  command bit: 0 = DACK active-low, 1 = active-high.
- ROT_PRI  input  1  command bit: 0 = fixed priority (ch0 highest), 1 = rotating.
- DISABLE  input  1  controller disable; blocks new HRQ only.
- SVC_END  input  1  one-cycle pulse from timing control: service of ACT_CH finished (TC/EOP).
- HRQ  output  1  hold request to CPU.
- DACK  output  NUM_CH  channel acknowledges, polarity per DACK_POL.
- ACT_VALID  output  1  a channel is granted.
- ACT_CH  output  CH_W  granted channel number.
- SREQ_CLR  output  NUM_CH  one-cycle pulse clearing the served channel's software request bit.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state = IDLE; HRQ = 0; ACT_VALID = 0; ACT_CH = 0; SREQ_CLR = 0.
  - Internal grant vector = 0, so DACK = all bits at their inactive level per DACK_POL (all ones when DACK_POL = 0).
  - Priority pointer TOP = 0; synchronisers cleared.
- DACK[i] = grant[i] XNOR DACK_POL. This is the only combinational output path.
- Effective request: eff[i] = ((dreq_sync[i] XOR DREQ_POL) AND NOT MASK[i]) OR SREQ[i]. SREQ bypasses the synchroniser.
- Priority:
  - Fixed: lowest index wins.
  - Rotating: search starts at TOP and wraps modulo NUM_CH.
  - On normal end of service of channel n (ROT_PRI = 1): TOP ← (n+1) mod NUM_CH.
  - TOP is unchanged in fixed mode and on abort. Switching ROT_PRI does not reset TOP.
- State IDLE:
  - If |eff AND NOT DISABLE → HOLD_REQ, HRQ ← 1.
  - With SYNC_STAGES = 2, DREQ set up before edge k gives HRQ high after edge k+2. SREQ set up before edge k gives HRQ high after edge k.
- State HOLD_REQ:
  - HRQ held at 1 until HLDA is sampled high.
  - HLDA high and |eff: latch the winner evaluated at that same edge into ACT_CH; set grant one-hot, ACT_VALID ← 1; → ACTIVE. DACK becomes active after that edge.
  - HLDA high and no eff (requests withdrawn): HRQ ← 0, → IDLE, no grant.
  - DISABLE going high in HOLD_REQ has no effect.
- State ACTIVE:
  - Grant frozen. No pre-emption by higher-priority requests, and no reaction to MASK, DREQ or DISABLE changes.
  - SVC_END sampled high: grant ← 0, ACT_VALID ← 0, HRQ ← 0, SREQ_CLR[ACT_CH] pulses for one cycle, rotate if enabled, → IDLE. ACT_CH keeps its last value.
  - HLDA sampled low without SVC_END (abort): same as above but no SREQ_CLR and no rotation.
  - SVC_END and HLDA low together are treated as a normal end.
- After any end of service, IDLE is re-evaluated on the next edge. The minimum HRQ low time is one cycle.
- SVC_END while not in ACTIVE is ignored.
- Reset asserted mid-service drops DACK/HRQ immediately (asynchronously).

Test Plan:
- Reset, DACK_POL = 0 → DACK = 4'b1111, HRQ = 0. Then DREQ = 4'b0100, MASK = 0, DREQ_POL = 0 set up before edge 1 → HRQ = 1 after edge 3. HLDA = 1 at edge 5 → DACK = 4'b1011, ACT_CH = 2. SVC_END at edge 8 → DACK = 4'b1111, HRQ = 0 after edge 8, SREQ_CLR = 0.
- Fixed priority, DREQ = 4'b1010 → grant ch1. Repeat three services → always ch1 while DREQ[1] is held.
- Rotating, DREQ = 4'b1111 held, four services → grant order 0, 1, 2, 3, then 0; TOP wraps 3→0.
- MASK = 4'b0001, DREQ = 4'b0001, SREQ = 0 → HRQ stays 0. Set SREQ = 4'b0001 → HRQ high after next edge, grant ch0; SVC_END → SREQ_CLR = 4'b0001 for exactly one cycle.
- In ACTIVE on ch3 (rotating, TOP = 3), drop HLDA → DACK inactive and HRQ = 0 next edge. Next grant with DREQ = 4'b1001 is ch3 again (no rotation on abort).
- Assert RESET_N low mid-ACTIVE (between edges) → DACK, HRQ, ACT_VALID inactive before the next edge. DISABLE = 1 in IDLE with DREQ = 4'b0001 → HRQ stays 0.
